// File: rtl/tlu_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tlu_stream_arbiter
//
// Round-robin framing arbiter. Shares one FWFT word sink among up to 16 FWFT
// word sources. Each grant copies a burst of up to MAX_BURST words from one
// source into a local buffer. The burst is then presented downstream as a
// frame: a header {4'hA, source id, word count} followed by the buffered words.
//
// Ports
//   BUS_CLK     in   clock
//   BUS_RST_N   in   asynchronous active-low reset
//   SRC_ENABLE  in   [N_SRC]     per-source enable, looked at only when granting
//   SRC_EMPTY   in   [N_SRC]     source FIFO empty flags
//   SRC_DATA    in   [16*N_SRC]  source FWFT data, source i at [16i+15:16i]
//   SRC_READ    out  [N_SRC]     pop strobe to the granted source (one-hot/zero)
//   OUT_READ    in   downstream pop strobe
//   OUT_EMPTY   out  low while a frame word is presented
//   OUT_DATA    out  [16] presented word, zero while OUT_EMPTY is high
//   BUSY        out  high whenever the arbiter is not idle
//   FRAME_CNT   out  [16] completed frame count, wraps to zero
// -----------------------------------------------------------------------------
module tlu_stream_arbiter #(
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic [N_SRC-1:0]     SRC_ENABLE,
    input  logic [N_SRC-1:0]     SRC_EMPTY,
    input  logic [16*N_SRC-1:0]  SRC_DATA,
    output logic [N_SRC-1:0]     SRC_READ,
    input  logic                 OUT_READ,
    output logic                 OUT_EMPTY,
    output logic [15:0]          OUT_DATA,
    output logic                 BUSY,
    output logic [15:0]          FRAME_CNT
);

    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
    localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(N_SRC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_HDR,
        S_DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [SRC_W-1:0] gnt_q, gnt_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      mem_q [MAX_BURST];

    logic             gnt_empty;
    logic [15:0]      gnt_data;
    logic [N_SRC-1:0] req;
    logic             req_found;
    logic [SRC_W-1:0] req_pick;
    logic             fill_rd;
    logic [15:0]      hdr_word;
    logic [15:0]      drain_word;

    // Granted source's FWFT view. Compared against each index rather than
    // indexed directly so the select stays in range for any N_SRC.
    always_comb begin
        gnt_empty = 1'b1;
        gnt_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_q == SRC_W'(i)) begin
                gnt_empty = SRC_EMPTY[i];
                gnt_data  = SRC_DATA[16*i +: 16];
            end
        end
    end

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        req       = ~SRC_EMPTY & SRC_ENABLE;
        req_found = 1'b0;
        req_pick  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (!req_found && idx == i && req[i]) begin
                    req_found = 1'b1;
                    req_pick  = SRC_W'(i);
                end
            end
        end
    end

    // A word is taken whenever the granted source has one and the buffer has room.
    assign fill_rd = (state_q == S_FILL) && !gnt_empty && (cnt_q < BURST_LIM);

    // NOTE: every variable gets a default at the top of a combinational block so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_found) begin
                    gnt_d   = req_pick;
                    cnt_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_rd) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_HDR;
                    end
                end else if (gnt_empty && cnt_q != '0) begin
                    // Source ran dry after at least one word: close the frame.
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (OUT_READ) begin
                    rd_d    = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (OUT_READ) begin
                    if (rd_q == cnt_q - 1'b1) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        rr_ptr_d    = (gnt_q == LAST_SRC) ? '0 : gnt_q + 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            rd_q        <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // NOTE: the burst buffer has no reset; every entry is written in FILL before
    // DRAIN can read it, so resetting it would only add reset fan-out.
    always_ff @(posedge BUS_CLK) begin
        for (int i = 0; i < MAX_BURST; i++) begin
            if (fill_rd && cnt_q == CNT_W'(i)) begin
                mem_q[i] <= gnt_data;
            end
        end
    end

    always_comb begin
        drain_word = '0;
        for (int i = 0; i < MAX_BURST; i++) begin
            if (rd_q == CNT_W'(i)) begin
                drain_word = mem_q[i];
            end
        end
    end

    assign hdr_word = {4'hA, 4'(gnt_q), cnt_q};

    always_comb begin
        SRC_READ = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (fill_rd && gnt_q == SRC_W'(i)) begin
                SRC_READ[i] = 1'b1;
            end
        end
    end

    always_comb begin
        OUT_EMPTY = 1'b1;
        OUT_DATA  = '0;
        case (state_q)
            S_HDR: begin
                OUT_EMPTY = 1'b0;
                OUT_DATA  = hdr_word;
            end
            S_DRAIN: begin
                OUT_EMPTY = 1'b0;
                OUT_DATA  = drain_word;
            end
            default: ;
        endcase
    end

    assign BUSY      = (state_q != S_IDLE);
    assign FRAME_CNT = frame_cnt_q;

endmodule
